// File: rtl/operand_lfsr_source_if.sv
// operand_lfsr_source_if: operand-pair stream plus run control between source and consumer
interface operand_lfsr_source_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic               start;
  logic [COUNT_W-1:0] num_pairs;
  logic               ready;
  logic               valid;
  logic [WIDTH-1:0]   a_out;
  logic [WIDTH-1:0]   b_out;
  logic [COUNT_W-1:0] pair_idx;
  logic               busy;
  logic               done;
  modport master (
    input  start, num_pairs, ready,
    output valid, a_out, b_out, pair_idx, busy, done
  );
  modport slave (
    output start, num_pairs, ready,
    input  valid, a_out, b_out, pair_idx, busy, done
  );
endinterface

// File: rtl/operand_lfsr_source.sv
// operand_lfsr_source: repeatable LFSR-driven (a,b) operand-pair generator with valid/ready output
module operand_lfsr_source #(
  parameter int          WIDTH   = 8,
  parameter logic [15:0] SEED_A  = 16'hACE1,
  parameter logic [15:0] SEED_B  = 16'h1D2B,
  parameter int          COUNT_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_lfsr_source_if.master bus
);
  localparam logic [15:0] L_SEED_A = (SEED_A == 16'h0) ? 16'h1 : SEED_A;
  localparam logic [15:0] L_SEED_B = (SEED_B == 16'h0) ? 16'h1 : SEED_B;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state, w_next;
  logic [15:0]        r_lfsr_a, r_lfsr_b, w_step_a, w_step_b;
  logic [COUNT_W-1:0] r_count, r_idx;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               w_load, w_xfer;
  function automatic logic [15:0] f_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction
  assign w_step_a = f_step(r_lfsr_a);
  assign w_step_b = f_step(r_lfsr_b);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // next state plus load/transfer strobes; start is only looked at in IDLE
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_xfer = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_load = bus.num_pairs != '0;
        w_next = w_load ? RUN : DONE;
      end
      RUN: begin
        w_xfer = bus.ready;
        if (bus.ready && r_count == COUNT_W'(1)) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end
  // datapath: reseed on load, advance both LFSRs on every accepted pair
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_lfsr_a <= L_SEED_A;
      r_lfsr_b <= L_SEED_B;
      r_count  <= '0;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (w_load) begin
      r_lfsr_a <= L_SEED_A;
      r_lfsr_b <= L_SEED_B;
      r_count  <= bus.num_pairs;
      r_idx    <= '0;
      r_a      <= L_SEED_A[WIDTH-1:0];
      r_b      <= L_SEED_B[WIDTH-1:0];
    end else if (w_xfer) begin
      r_lfsr_a <= w_step_a;
      r_lfsr_b <= w_step_b;
      r_count  <= r_count - COUNT_W'(1);
      r_idx    <= r_idx + COUNT_W'(1);
      r_a      <= w_step_a[WIDTH-1:0];
      r_b      <= w_step_b[WIDTH-1:0];
    end
  assign bus.valid    = r_state == RUN;
  assign bus.busy     = r_state == RUN;
  assign bus.done     = r_state == DONE;
  assign bus.a_out    = r_a;
  assign bus.b_out    = r_b;
  assign bus.pair_idx = r_idx;
endmodule

// File: tb/tb_operand_lfsr_source.sv
// tb_operand_lfsr_source: directed scenarios checked against a sequence-level model every cycle
`timescale 1ns/100ps
module tb_operand_lfsr_source;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  operand_lfsr_source_if #(.WIDTH(8), .COUNT_W(8)) bus ();
  operand_lfsr_source_if #(.WIDTH(8), .COUNT_W(8)) bus2 ();
  operand_lfsr_source #(.WIDTH(8), .SEED_A(16'hACE1), .SEED_B(16'h1D2B), .COUNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  operand_lfsr_source #(.WIDTH(8), .SEED_A(16'h0000), .SEED_B(16'h1D2B), .COUNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] nth(input logic [15:0] seed, input int n);
    logic [15:0] s = seed;
    for (int i = 0; i < n; i++) begin
      logic lsb = s[0];
      s = s >> 1;
      if (lsb) s = s ^ 16'hB400;
    end
    return s;
  endfunction
  // model: a run is "pair k of the seed sequence is on offer until accepted"
  int m_mode = 0;
  int m_idx = 0;
  int m_rem = 0;
  int m_xfers = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_mode = 0;
      m_idx  = 0;
      m_rem  = 0;
    end else if (m_mode == 0) begin
      if (bus.start && bus.num_pairs != 0) begin
        m_mode = 1; m_idx = 0; m_rem = int'(bus.num_pairs); m_xfers = 0;
      end else if (bus.start) begin
        m_mode = 2; m_xfers = 0;
      end
    end else if (m_mode == 1) begin
      if (bus.ready) begin
        m_idx++; m_rem--; m_xfers++;
        if (m_rem == 0) m_mode = 2;
      end
    end else m_mode = 0;
  always @(negedge clk)
    if (rst_n) begin
      logic [15:0] ea, eb;
      chk("valid", 32'(bus.valid), 32'(m_mode == 1));
      chk("busy", 32'(bus.busy), 32'(m_mode == 1));
      chk("done", 32'(bus.done), 32'(m_mode == 2));
      if (m_mode == 1) begin
        ea = nth(16'hACE1, m_idx);
        eb = nth(16'h1D2B, m_idx);
        chk("a_out", 32'(bus.a_out), 32'(ea[7:0]));
        chk("b_out", 32'(bus.b_out), 32'(eb[7:0]));
        chk("pair_idx", 32'(bus.pair_idx), 32'(m_idx));
      end
    end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic wait_done;
    int n = 0;
    while (!bus.done && n < 60) begin
      tick;
      n++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
    tick;
  endtask
  initial begin
    logic [15:0] s1, s2;
    bus.start = 0; bus.num_pairs = 0; bus.ready = 0;
    bus2.start = 0; bus2.num_pairs = 0; bus2.ready = 0;
    s1 = nth(16'hACE1, 1);
    s2 = nth(16'hACE1, 2);
    chk("model_step1", 32'(s1), 32'hE270);
    chk("model_step2", 32'(s2), 32'h7138);
    #3;
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_a", 32'(bus.a_out), 0);
    chk("rst_b", 32'(bus.b_out), 0);
    chk("rst_idx", 32'(bus.pair_idx), 0);
    #10 rst_n = 1;
    tick;
    // scenario 1: three pairs back to back
    bus.start = 1; bus.num_pairs = 3; bus.ready = 1;
    tick;
    bus.start = 0;
    chk("s1_a0", 32'(bus.a_out), 32'hE1);
    tick;
    chk("s1_a1", 32'(bus.a_out), 32'h70);
    tick;
    chk("s1_a2", 32'(bus.a_out), 32'h38);
    chk("s1_idx2", 32'(bus.pair_idx), 2);
    tick;
    chk("s1_done", 32'(bus.done), 1);
    chk("s1_valid_off", 32'(bus.valid), 0);
    tick;
    chk("s1_done_off", 32'(bus.done), 0);
    chk("s1_busy_off", 32'(bus.busy), 0);
    chk("s1_xfers", 32'(m_xfers), 3);
    // scenario 2: ready toggling
    bus.ready = 0; bus.start = 1; bus.num_pairs = 4;
    tick;
    bus.start = 0;
    for (int i = 0; i < 60 && !bus.done; i++) begin
      bus.ready = ~bus.ready;
      tick;
    end
    chk("s2_done", 32'(bus.done), 1);
    chk("s2_xfers", 32'(m_xfers), 4);
    bus.ready = 1;
    tick;
    // scenario 3: zero pairs
    bus.start = 1; bus.num_pairs = 0;
    tick;
    bus.start = 0;
    chk("s3_done", 32'(bus.done), 1);
    chk("s3_valid", 32'(bus.valid), 0);
    tick;
    chk("s3_done_off", 32'(bus.done), 0);
    chk("s3_xfers", 32'(m_xfers), 0);
    // scenario 4: start re-asserted mid-run is ignored
    bus.start = 1; bus.num_pairs = 5;
    tick;
    bus.num_pairs = 9;
    tick;
    tick;
    bus.start = 0;
    wait_done;
    chk("s4_xfers", 32'(m_xfers), 5);
    // scenario 5: reset pulse after two transfers
    bus.start = 1; bus.num_pairs = 5;
    tick;
    bus.start = 0;
    tick;
    tick;
    chk("s5_idx_before", 32'(bus.pair_idx), 2);
    rst_n = 0;
    #0.5;
    chk("s5_valid_async", 32'(bus.valid), 0);
    chk("s5_busy_async", 32'(bus.busy), 0);
    #0.5 rst_n = 1;
    tick;
    chk("s5_no_done", 32'(bus.done), 0);
    bus.start = 1; bus.num_pairs = 1;
    tick;
    bus.start = 0;
    chk("s5_a_reseed", 32'(bus.a_out), 32'hE1);
    wait_done;
    // scenario 6: zero seed is replaced by one
    bus2.start = 1; bus2.num_pairs = 2; bus2.ready = 1;
    tick;
    bus2.start = 0;
    chk("s6_valid", 32'(bus2.valid), 1);
    chk("s6_a0", 32'(bus2.a_out), 32'h01);
    tick;
    chk("s6_a1", 32'(bus2.a_out), 32'h00);
    chk("s6_idx1", 32'(bus2.pair_idx), 1);
    tick;
    chk("s6_done", 32'(bus2.done), 1);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
